xif_copro_sb_regfile: RTL

XIF_COPRO_SB_REGFILE -- requirements
Module: xif_copro_sb_regfile

---
 rtl/xif_copro_sb_regfile.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/xif_copro_sb_regfile.sv
// ---------------------------------------------------------------------------
// xif_copro_sb_regfile
//
// Coprocessor register file with a destination scoreboard. An issue stage
// reserves (allocates) a destination register. The reservation is released
// when a write-back lands on that register.
//
// Parameters
//   DATA_WIDTH      register width in bits
//   NUM_WORDS       number of registers (2..64)
//   NR_READ_PORTS   combinational read ports
//   NR_WRITE_PORTS  write ports; the highest index wins on an address clash
//   ZERO_REG        1: register 0 reads 0, ignores writes, is never busy
//
// Ports
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   raddr_i / rdata_o / rbusy_o     per read port: address, data, busy bit
//   waddr_i / wdata_i / we_i        per write port: address, data, enable
//   alloc_valid_i / alloc_addr_i /
//   alloc_ready_o                   destination reservation handshake
//   flush_i                         drop every reservation (data kept)
//   busy_o                          scoreboard vector
//   outstanding_o                   number of set busy bits (registered)
//
// Handshake: a reservation is taken on a rising clk_i edge when
// alloc_valid_i and alloc_ready_o are both 1. alloc_ready_o does not depend
// on alloc_valid_i. A requester holding valid keeps alloc_addr_i stable until
// it sees ready.
//
// Addresses >= NUM_WORDS read 0 and are never busy. Writes to them are
// dropped, and an alloc to them has no effect.
//
// Optional feature: define XIF_COPRO_SB_REGFILE_BYPASS_EN so that a read
// sees a write that lands in the same cycle (data forwarded, busy reported
// 0). Without it, reads see only the stored state.
// ---------------------------------------------------------------------------
module xif_copro_sb_regfile #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned NUM_WORDS      = 32,
  parameter int unsigned NR_READ_PORTS  = 3,
  parameter int unsigned NR_WRITE_PORTS = 2,
  parameter int unsigned ZERO_REG       = 0,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned CW = $clog2(NUM_WORDS + 1)
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [NR_READ_PORTS-1:0][AW-1:0]             raddr_i,
  output logic [NR_READ_PORTS-1:0][DATA_WIDTH-1:0]     rdata_o,
  output logic [NR_READ_PORTS-1:0]                     rbusy_o,
  input  logic [NR_WRITE_PORTS-1:0][AW-1:0]            waddr_i,
  input  logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_WRITE_PORTS-1:0]                    we_i,
  input  logic                                         alloc_valid_i,
  input  logic [AW-1:0]                                alloc_addr_i,
  output logic                                         alloc_ready_o,
  input  logic                                         flush_i,
  output logic [NUM_WORDS-1:0]                         busy_o,
  output logic [CW-1:0]                                outstanding_o
);

  // An address is "real" when it maps to a register that can be written or
  // reserved. Out-of-range addresses and a hardwired r0 are not real.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NUM_WORDS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
  logic [NUM_WORDS-1:0]  busy_q, busy_d;
  logic [CW-1:0]         cnt_q, cnt_d, rel_cnt;

  // Per-register write decode. Later ports overwrite earlier ones, so the
  // highest-index port wins an address clash.
  logic [NUM_WORDS-1:0]  wr_hit;
  logic [DATA_WIDTH-1:0] wr_data [NUM_WORDS];

  always_comb begin
    for (int w = 0; w < NUM_WORDS; w++) begin
      wr_hit[w]  = 1'b0;
      wr_data[w] = '0;
      for (int j = 0; j < NR_WRITE_PORTS; j++) begin
        if (we_i[j] && addr_ok(waddr_i[j]) && (waddr_i[j] == AW'(w))) begin
          wr_hit[w]  = 1'b1;
          wr_data[w] = wdata_i[j];
        end
      end
    end
  end

  // Reservation handshake. A busy register cannot be re-reserved. This also
  // rules out a release and a re-alloc of one address in the same cycle.
  logic alloc_ok, alloc_busy, alloc_fire;

  always_comb begin
    alloc_ok      = addr_ok(alloc_addr_i);
    alloc_busy    = alloc_ok && busy_q[alloc_addr_i];
    alloc_ready_o = !flush_i && !alloc_busy;
    alloc_fire    = alloc_valid_i && alloc_ready_o && alloc_ok;
  end

  // Writes release first and the alloc sets afterwards. If an alloc and a
  // write hit the same idle register, the register therefore stays busy.
  // Flush overrides both.
  always_comb begin
    busy_d  = busy_q & ~wr_hit;
    if (alloc_fire) busy_d = busy_d | (NUM_WORDS'(1) << alloc_addr_i);
    if (flush_i) busy_d = '0;

    // Only writes to registers that were actually busy lower the count.
    rel_cnt = '0;
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (busy_q[w] && wr_hit[w]) rel_cnt = rel_cnt + CW'(1);
    end
    cnt_d = flush_i ? '0 : (cnt_q - rel_cnt + CW'(alloc_fire));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < NUM_WORDS; w++) mem_q[w] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        if (wr_hit[w]) mem_q[w] <= wr_data[w];
      end
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NR_READ_PORTS; i++) begin
      rdata_o[i] = '0;
      rbusy_o[i] = 1'b0;
      if (addr_ok(raddr_i[i])) begin
        rdata_o[i] = mem_q[raddr_i[i]];
        rbusy_o[i] = busy_q[raddr_i[i]];
`ifdef XIF_COPRO_SB_REGFILE_BYPASS_EN
        // A write landing this cycle is forwarded. It also releases the
        // register, so the read reports not busy.
        if (wr_hit[raddr_i[i]]) begin
          rdata_o[i] = wr_data[raddr_i[i]];
          rbusy_o[i] = 1'b0;
        end
`endif
      end
    end
  end

  assign busy_o        = busy_q;
  assign outstanding_o = cnt_q;

endmodule
